sample1_sweep_ctrl: RTL and testbench

SAMPLE1_SWEEP_CTRL -- requirements
Module: sample1_sweep_ctrl

---
 rtl/sample1_sweep_ctrl_pkg.sv | 16 +
 rtl/sweep_hold_timer.sv | 34 +++
 rtl/sample1_sweep_ctrl.sv | 115 +++++++++++
 tb/tb_sample1_sweep_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample1_sweep_ctrl_pkg.sv
// Shared constants for the gate truth-table sweep controller.
package sample1_pkg;

    // FSM encoding, kept as plain constants for tools that dislike enums
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_APPLY = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Two gate inputs give four combinations, indexed by a 2-bit step
    localparam int STEP_W = 2;
    localparam logic [STEP_W-1:0] LAST_STEP = 2'd3;

    // Hold counter width; the hold count itself is limited to 2..65535
    localparam int HOLD_W = 16;

endpackage

// File: rtl/sweep_hold_timer.sv
// Down-counter that times how long each input combination is held.
// Loading takes priority; otherwise it counts down to zero and parks there.
module sweep_hold_timer
    import sample1_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [HOLD_W-1:0] value_i,
    output logic              zero_o
);

    logic [HOLD_W-1:0] cnt_q, cnt_d;

    // Next count: reload on request, else decrement without ever wrapping
    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = value_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sample1_sweep_ctrl.sv
// Sweeps the two inputs of an external gate through 00,01,10,11, holding
// each for HOLD_CYCLES cycles and capturing the gate output on the last
// cycle of each hold into a 4-bit truth table.
module sample1_sweep_ctrl
    import sample1_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 50
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              z,
    output logic              x,
    output logic              y,
    output logic              busy,
    output logic              done,
    output logic [3:0]        truth,
    output logic [STEP_W-1:0] step
);

    localparam logic [HOLD_W-1:0] RELOAD = HOLD_W'(HOLD_CYCLES - 1);

    logic [1:0]        state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [3:0]        truth_q, truth_d;
    logic              x_q, y_q, busy_q, done_q;
    logic              busy_d, done_d, x_d, y_d;
    logic              tmr_load, tmr_zero;
    logic [HOLD_W-1:0] tmr_val;

    sweep_hold_timer u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (tmr_load),
        .value_i (tmr_val),
        .zero_o  (tmr_zero)
    );

    // Next-state logic; abort always wins, including on a sampling edge
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        truth_d  = truth_q;
        tmr_load = 1'b0;
        tmr_val  = RELOAD;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d  = ST_APPLY;
                    step_d   = '0;
                    truth_d  = '0;
                    tmr_load = 1'b1;
                end
            end
            ST_APPLY: begin
                if (abort) begin
                    state_d  = ST_IDLE;
                    step_d   = '0;
                    tmr_load = 1'b1;
                    tmr_val  = '0;
                end else if (tmr_zero) begin
                    truth_d[step_q] = z;
                    tmr_load = 1'b1;
                    if (step_q == LAST_STEP) begin
                        state_d = ST_DONE;
                        step_d  = '0;
                        tmr_val = '0;
                    end else begin
                        step_d = step_q + 2'd1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are derived from the next state so they register cleanly
    always_comb begin
        busy_d = (state_d == ST_APPLY);
        done_d = (state_d == ST_DONE);
        x_d    = busy_d & step_d[1];
        y_d    = busy_d & step_d[0];
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            truth_q <= '0;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            truth_q <= truth_d;
            x_q     <= x_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign x     = x_q;
    assign y     = y_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign truth = truth_q;
    assign step  = step_q;

endmodule

// File: tb/tb_sample1_sweep_ctrl.sv
// Directed bench for the sweep controller: one DUT with the default hold
// of 50 cycles and one with the minimum hold of 2 cycles.
module tb_sample1_sweep_ctrl;

    localparam int HA = 50;
    localparam int HB = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
    logic [1:0] mode_a = 2'd0, mode_b = 2'd0;
    logic       z_a, x_a, y_a, busy_a, done_a;
    logic       z_b, x_b, y_b, busy_b, done_b;
    logic [3:0] truth_a, truth_b;
    logic [1:0] step_a, step_b;

    int n_chk = 0;
    int n_bad = 0;

    // Gate under test: 0 AND, 1 XOR, 2 OR, 3 NAND
    function automatic logic gate(input logic [1:0] m, input logic a, input logic b);
        case (m)
            2'd0:    return a & b;
            2'd1:    return a ^ b;
            2'd2:    return a | b;
            default: return ~(a & b);
        endcase
    endfunction

    assign z_a = gate(mode_a, x_a, y_a);
    assign z_b = gate(mode_b, x_b, y_b);

    always #5 clk = ~clk;

    sample1_sweep_ctrl #(.HOLD_CYCLES(HA)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .z(z_a),
        .x(x_a), .y(y_a), .busy(busy_a), .done(done_a), .truth(truth_a), .step(step_a)
    );

    sample1_sweep_ctrl #(.HOLD_CYCLES(HB)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .z(z_b),
        .x(x_b), .y(y_b), .busy(busy_b), .done(done_b), .truth(truth_b), .step(step_b)
    );

    // Reset asserted before any clock edge must clear everything on its own
    task automatic test_reset;
        logic [9:0] got;
        #2 rst_n = 1'b0;
        #1;
        got = {busy_a, done_a, step_a, x_a, y_a, truth_a};
        n_chk++;
        if (got !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_a got=%b exp=%b", got, 10'd0);
        end
        got = {busy_b, done_b, step_b, x_b, y_b, truth_b};
        n_chk++;
        if (got !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_b got=%b exp=%b", got, 10'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Full AND sweep, checked every cycle: {busy,done,step,x,y}
    task automatic test_and_sweep;
        logic [1:0] es;
        logic [5:0] got, exp;
        mode_a = 2'd0;
        @(negedge clk) start_a = 1'b1;
        for (int k = 0; k <= 4*HA+1; k++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (k < 4*HA) begin
                es  = 2'(k / HA);
                exp = {1'b1, 1'b0, es, es[1], es[0]};
            end else if (k == 4*HA) begin
                exp = 6'b010000;
            end else begin
                exp = 6'b000000;
            end
            got = {busy_a, done_a, step_a, x_a, y_a};
            n_chk++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL and_seq k=%0d got=%b exp=%b", k, got, exp);
            end
        end
        n_chk++;
        if (truth_a !== 4'b1000) begin
            n_bad++;
            $display("FAIL and_truth got=%b exp=1000", truth_a);
        end
    endtask

    // XOR then OR sweeps; truth must clear on start, busy 4*HA, one done
    task automatic test_xor_or;
        logic [3:0] exp_t [2];
        logic [1:0] modes [2];
        int busy_n, done_n;
        exp_t[0] = 4'b0110; modes[0] = 2'd1;
        exp_t[1] = 4'b1110; modes[1] = 2'd2;
        for (int m = 0; m < 2; m++) begin
            mode_a = modes[m];
            busy_n = 0;
            done_n = 0;
            @(negedge clk) start_a = 1'b1;
            for (int k = 0; k < 4*HA+5; k++) begin
                @(negedge clk);
                start_a = 1'b0;
                if (k == 0) begin
                    n_chk++;
                    if (truth_a !== 4'b0000) begin
                        n_bad++;
                        $display("FAIL clear_on_start m=%0d got=%b exp=0000", m, truth_a);
                    end
                end
                busy_n += int'(busy_a);
                done_n += int'(done_a);
            end
            n_chk++;
            if (busy_n != 4*HA) begin
                n_bad++;
                $display("FAIL busy_len m=%0d got=%0d exp=%0d", m, busy_n, 4*HA);
            end
            n_chk++;
            if (done_n != 1) begin
                n_bad++;
                $display("FAIL done_cnt m=%0d got=%0d exp=1", m, done_n);
            end
            n_chk++;
            if (truth_a !== exp_t[m]) begin
                n_bad++;
                $display("FAIL gate_truth m=%0d got=%b exp=%b", m, truth_a, exp_t[m]);
            end
        end
    endtask

    // Abort with OR gate once combination 2 is captured (mid step 3) and
    // again exactly on the final sampling edge: both leave truth=0110
    task automatic test_abort;
        int last_k [2];
        int done_n, busy_n;
        logic [5:0] got;
        last_k[0] = 3*HA + 10;
        last_k[1] = 4*HA - 1;
        mode_a = 2'd2;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk) start_a = 1'b1;
            for (int k = 0; k <= last_k[c]; k++) begin
                @(negedge clk);
                start_a = 1'b0;
            end
            abort_a = 1'b1;
            @(negedge clk);
            abort_a = 1'b0;
            got = {busy_a, done_a, step_a, x_a, y_a};
            n_chk++;
            if (got !== 6'b000000) begin
                n_bad++;
                $display("FAIL abort_state c=%0d got=%b exp=000000", c, got);
            end
            n_chk++;
            if (truth_a !== 4'b0110) begin
                n_bad++;
                $display("FAIL abort_truth c=%0d got=%b exp=0110", c, truth_a);
            end
            done_n = 0;
            busy_n = 0;
            repeat (10) begin
                @(negedge clk);
                done_n += int'(done_a);
                busy_n += int'(busy_a);
            end
            n_chk++;
            if (done_n != 0 || busy_n != 0) begin
                n_bad++;
                $display("FAIL abort_quiet c=%0d done=%0d busy=%0d exp=0/0", c, done_n, busy_n);
            end
        end
    endtask

    // start pulsed mid-APPLY and in DONE must change nothing
    task automatic test_start_ignored;
        logic [1:0] es;
        logic [5:0] got, exp;
        int done_n;
        done_n = 0;
        mode_a = 2'd0;
        @(negedge clk) start_a = 1'b1;
        for (int k = 0; k <= 4*HA+2; k++) begin
            @(negedge clk);
            if (k < 4*HA) begin
                es  = 2'(k / HA);
                exp = {1'b1, 1'b0, es, es[1], es[0]};
            end else if (k == 4*HA) begin
                exp = 6'b010000;
            end else begin
                exp = 6'b000000;
            end
            got = {busy_a, done_a, step_a, x_a, y_a};
            n_chk++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL ign_seq k=%0d got=%b exp=%b", k, got, exp);
            end
            done_n += int'(done_a);
            start_a = (k == HA + 7) || (k == 2*HA + 3) || (k == 4*HA);
        end
        start_a = 1'b0;
        n_chk++;
        if (done_n != 1) begin
            n_bad++;
            $display("FAIL ign_done_cnt got=%0d exp=1", done_n);
        end
        n_chk++;
        if (truth_a !== 4'b1000) begin
            n_bad++;
            $display("FAIL ign_truth got=%b exp=1000", truth_a);
        end
    endtask

    // Reset mid step 1 clears outputs with no clock edge; then a clean rerun
    task automatic test_reset_mid;
        logic [9:0] got;
        int done_n;
        mode_a = 2'd3;
        @(negedge clk) start_a = 1'b1;
        for (int k = 0; k <= HA + 10; k++) begin
            @(negedge clk);
            start_a = 1'b0;
        end
        got = {busy_a, done_a, step_a, x_a, y_a, truth_a};
        n_chk++;
        if (got !== 10'b1_0_01_0_1_0001) begin
            n_bad++;
            $display("FAIL pre_reset got=%b exp=%b", got, 10'b1_0_01_0_1_0001);
        end
        #2 rst_n = 1'b0;
        #1;
        got = {busy_a, done_a, step_a, x_a, y_a, truth_a};
        n_chk++;
        if (got !== 10'd0) begin
            n_bad++;
            $display("FAIL async_reset got=%b exp=%b", got, 10'd0);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if (busy_a !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset busy=%b exp=0", busy_a);
        end
        mode_a = 2'd0;
        done_n = 0;
        start_a = 1'b1;
        for (int k = 0; k < 4*HA+4; k++) begin
            @(negedge clk);
            start_a = 1'b0;
            done_n += int'(done_a);
        end
        n_chk++;
        if (done_n != 1 || truth_a !== 4'b1000) begin
            n_bad++;
            $display("FAIL rerun done=%0d truth=%b exp=1/1000", done_n, truth_a);
        end
    endtask

    // Minimum hold: two cycles per combination, eight busy cycles
    task automatic test_hold2;
        logic [1:0] es;
        logic [5:0] got, exp;
        mode_b = 2'd0;
        @(negedge clk) start_b = 1'b1;
        for (int k = 0; k <= 4*HB+1; k++) begin
            @(negedge clk);
            start_b = 1'b0;
            if (k < 4*HB) begin
                es  = 2'(k / HB);
                exp = {1'b1, 1'b0, es, es[1], es[0]};
            end else if (k == 4*HB) begin
                exp = 6'b010000;
            end else begin
                exp = 6'b000000;
            end
            got = {busy_b, done_b, step_b, x_b, y_b};
            n_chk++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL hold2_seq k=%0d got=%b exp=%b", k, got, exp);
            end
        end
        n_chk++;
        if (truth_b !== 4'b1000) begin
            n_bad++;
            $display("FAIL hold2_truth got=%b exp=1000", truth_b);
        end
    endtask

    initial begin
        test_reset();
        test_and_sweep();
        test_xor_or();
        test_abort();
        test_start_ignored();
        test_reset_mid();
        test_hold2();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
